reg_file_8x8: RTL and testbench

Eight-entry, 8-bit general-purpose register file that supplies the two signed operands (A, B) to the ALU function units (`OrUnit8` and peers) and accepts the ALU result back as write-back data. It is the producer/consumer end of the ALU operand/result interface. It sits between the instruction decoder and the ALU in the single-cycle datapath. Read outputs are registered with write-through bypass, and a stall input can freeze them.

---
 rtl/cpu_defs.sv | 14 +
 rtl/reg_read_port.sv | 40 ++++
 rtl/reg_file_8x8.sv | 104 ++++++++++
 tb/tb_reg_file_8x8.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared datapath defaults for the register file, ALU units and decoder.
// Also holds the read-port state encoding.
package cpu_defs;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_VALID = 1'b1
    } rd_state_e;

endpackage

// File: rtl/reg_read_port.sv
// One registered read port with write-through bypass.
// Instantiated once per ALU operand.
module reg_read_port
    import cpu_defs::*;
#(
    parameter int DATA_W   = cpu_defs::DATA_W,
    parameter int ADDR_W   = cpu_defs::ADDR_W,
    parameter int NUM_REGS = cpu_defs::NUM_REGS
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               hold,
    input  logic                               we,
    input  logic [ADDR_W-1:0]                  waddr,
    input  logic [DATA_W-1:0]                  wdata,
    input  logic [ADDR_W-1:0]                  raddr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]    regs,
    output logic [DATA_W-1:0]                  rdata
);

    logic [DATA_W-1:0] rd_next;

    // Pick the value to capture: same-edge write wins over stored data
    always_comb begin
        rd_next = regs[raddr];
        if (we && (waddr == raddr)) begin
            rd_next = wdata;
        end
    end

    // Output register, frozen while the pipeline is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (!hold) begin
            rdata <= rd_next;
        end
    end

endmodule

// File: rtl/reg_file_8x8.sv
// Eight-entry operand register file feeding the ALU units.
// Owns storage, write-back, the written mask and the read-valid state.
module reg_file_8x8
    import cpu_defs::*;
#(
    parameter int DATA_W   = cpu_defs::DATA_W,
    parameter int ADDR_W   = cpu_defs::ADDR_W,
    parameter int NUM_REGS = cpu_defs::NUM_REGS
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic                      WRITEENABLE,
    input  logic [ADDR_W-1:0]         WRITEREG,
    input  logic signed [DATA_W-1:0]  WRITEDATA,
    input  logic [ADDR_W-1:0]         READREG1,
    input  logic [ADDR_W-1:0]         READREG2,
    input  logic                      HOLD,
    output logic signed [DATA_W-1:0]  REGOUT1,
    output logic signed [DATA_W-1:0]  REGOUT2,
    output logic                      OUTVALID,
    output logic [NUM_REGS-1:0]       WRITTEN
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]               rd1;
    logic [DATA_W-1:0]               rd2;
    rd_state_e                       state_q;
    rd_state_e                       state_d;

    // Storage write-back; reset drops any in-flight write
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            regs <= '0;
        end else if (WRITEENABLE) begin
            regs[WRITEREG] <= WRITEDATA;
        end
    end

    // Sticky per-register written flags
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            WRITTEN <= '0;
        end else if (WRITEENABLE) begin
            WRITTEN[WRITEREG] <= 1'b1;
        end
    end

    // Read-valid state register
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave IDLE on the first unstalled edge; only reset returns
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE:  if (!HOLD) state_d = RD_VALID;
            RD_VALID: state_d = RD_VALID;
            default:  state_d = RD_IDLE;
        endcase
    end

    assign OUTVALID = (state_q == RD_VALID);

    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_a (
        .clk   (CLK),
        .rst_n (RESETN),
        .hold  (HOLD),
        .we    (WRITEENABLE),
        .waddr (WRITEREG),
        .wdata (WRITEDATA),
        .raddr (READREG1),
        .regs  (regs),
        .rdata (rd1)
    );

    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_b (
        .clk   (CLK),
        .rst_n (RESETN),
        .hold  (HOLD),
        .we    (WRITEENABLE),
        .waddr (WRITEREG),
        .wdata (WRITEDATA),
        .raddr (READREG2),
        .regs  (regs),
        .rdata (rd2)
    );

    assign REGOUT1 = rd1;
    assign REGOUT2 = rd2;

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed self-checking bench for reg_file_8x8.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_reg_file_8x8;

    logic              CLK;
    logic              RESETN;
    logic              WRITEENABLE;
    logic [2:0]        WRITEREG;
    logic signed [7:0] WRITEDATA;
    logic [2:0]        READREG1;
    logic [2:0]        READREG2;
    logic              HOLD;
    logic signed [7:0] REGOUT1;
    logic signed [7:0] REGOUT2;
    logic              OUTVALID;
    logic [7:0]        WRITTEN;

    int checks = 0;
    int errors = 0;

    reg_file_8x8 dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .WRITEENABLE (WRITEENABLE),
        .WRITEREG    (WRITEREG),
        .WRITEDATA   (WRITEDATA),
        .READREG1    (READREG1),
        .READREG2    (READREG2),
        .HOLD        (HOLD),
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .OUTVALID    (OUTVALID),
        .WRITTEN     (WRITTEN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        // dirty the state, then pull reset mid-cycle
        WRITEENABLE = 1'b1; WRITEREG = 3'd2; WRITEDATA = 8'h5A;
        READREG1 = 3'd2; READREG2 = 3'd2; HOLD = 1'b0;
        tick();
        WRITEENABLE = 1'b0;
        #2;
        RESETN = 1'b0;
        #1;
        checks++;
        if (REGOUT1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_regout1: got %h expected 00", REGOUT1);
        end
        checks++;
        if (REGOUT2 !== 8'h00) begin
            errors++;
            $display("FAIL reset_regout2: got %h expected 00", REGOUT2);
        end
        checks++;
        if (OUTVALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_outvalid: got %b expected 0", OUTVALID);
        end
        checks++;
        if (WRITTEN !== 8'h00) begin
            errors++;
            $display("FAIL reset_written: got %h expected 00", WRITTEN);
        end
        @(posedge CLK);
        #2;
        RESETN = 1'b1;
    endtask

    task automatic test_write_read();
        @(posedge CLK);
        #1;
        WRITEENABLE = 1'b1; WRITEREG = 3'd3; WRITEDATA = 8'hD4;
        READREG1 = 3'd0; READREG2 = 3'd0; HOLD = 1'b0;
        tick();
        checks++;
        if (OUTVALID !== 1'b1) begin
            errors++;
            $display("FAIL wr_outvalid: got %b expected 1", OUTVALID);
        end
        checks++;
        if (REGOUT1 !== 8'h00) begin
            errors++;
            $display("FAIL wr_r0_cleared: got %h expected 00", REGOUT1);
        end
        WRITEENABLE = 1'b0;
        READREG1 = 3'd3; READREG2 = 3'd3;
        tick();
        checks++;
        if (REGOUT1 !== -8'sd44) begin
            errors++;
            $display("FAIL rd_r3_port1: got %h expected d4", REGOUT1);
        end
        checks++;
        if (REGOUT2 !== -8'sd44) begin
            errors++;
            $display("FAIL rd_r3_port2: got %h expected d4", REGOUT2);
        end
        checks++;
        if (WRITTEN !== 8'h08) begin
            errors++;
            $display("FAIL rd_written: got %h expected 08", WRITTEN);
        end
    endtask

    task automatic test_bypass();
        WRITEENABLE = 1'b1; WRITEREG = 3'd5; WRITEDATA = 8'd10;
        READREG1 = 3'd0; READREG2 = 3'd0;
        tick();
        WRITEDATA = 8'd15;
        READREG1 = 3'd5; READREG2 = 3'd5;
        tick();
        checks++;
        if (REGOUT1 !== 8'h0F) begin
            errors++;
            $display("FAIL bypass_port1: got %h expected 0f", REGOUT1);
        end
        checks++;
        if (REGOUT2 !== 8'h0F) begin
            errors++;
            $display("FAIL bypass_port2: got %h expected 0f", REGOUT2);
        end
        // one port bypasses, other reads stored r3
        WRITEREG = 3'd6; WRITEDATA = 8'h77;
        READREG1 = 3'd6; READREG2 = 3'd3;
        tick();
        checks++;
        if (REGOUT1 !== 8'h77) begin
            errors++;
            $display("FAIL bypass_single_p1: got %h expected 77", REGOUT1);
        end
        checks++;
        if (REGOUT2 !== 8'hD4) begin
            errors++;
            $display("FAIL bypass_single_p2: got %h expected d4", REGOUT2);
        end
        WRITEENABLE = 1'b0;
        READREG1 = 3'd5; READREG2 = 3'd6;
        tick();
        checks++;
        if (REGOUT1 !== 8'h0F || REGOUT2 !== 8'h77) begin
            errors++;
            $display("FAIL bypass_stored: got %h/%h expected 0f/77",
                     REGOUT1, REGOUT2);
        end
    endtask

    task automatic test_hold();
        WRITEENABLE = 1'b1; WRITEREG = 3'd1; WRITEDATA = 8'd1;
        READREG1 = 3'd1; READREG2 = 3'd1; HOLD = 1'b0;
        tick();
        WRITEENABLE = 1'b0;
        tick();
        checks++;
        if (REGOUT1 !== 8'd1 || REGOUT2 !== 8'd1) begin
            errors++;
            $display("FAIL hold_setup: got %h/%h expected 01/01",
                     REGOUT1, REGOUT2);
        end
        HOLD = 1'b1;
        WRITEENABLE = 1'b1; WRITEDATA = 8'd11;
        tick();
        checks++;
        if (REGOUT1 !== 8'd1 || REGOUT2 !== 8'd1) begin
            errors++;
            $display("FAIL hold_frozen: got %h/%h expected 01/01",
                     REGOUT1, REGOUT2);
        end
        WRITEENABLE = 1'b0;
        tick();
        checks++;
        if (REGOUT1 !== 8'd1 || OUTVALID !== 1'b1) begin
            errors++;
            $display("FAIL hold_frozen2: got %h v%b expected 01 v1",
                     REGOUT1, OUTVALID);
        end
        checks++;
        if (WRITTEN !== 8'h6A) begin
            errors++;
            $display("FAIL hold_written: got %h expected 6a", WRITTEN);
        end
        HOLD = 1'b0;
        tick();
        checks++;
        if (REGOUT1 !== 8'd11 || REGOUT2 !== 8'd11) begin
            errors++;
            $display("FAIL hold_release: got %h/%h expected 0b/0b",
                     REGOUT1, REGOUT2);
        end
    endtask

    task automatic test_independent();
        logic [7:0] c;
        WRITEENABLE = 1'b1; WRITEREG = 3'd0; WRITEDATA = 8'sd1;
        tick();
        WRITEREG = 3'd7; WRITEDATA = -8'sd1;
        tick();
        WRITEENABLE = 1'b0;
        READREG1 = 3'd0; READREG2 = 3'd7;
        tick();
        checks++;
        if (REGOUT1 !== 8'h01) begin
            errors++;
            $display("FAIL indep_port1: got %h expected 01", REGOUT1);
        end
        checks++;
        if (REGOUT2 !== 8'hFF) begin
            errors++;
            $display("FAIL indep_port2: got %h expected ff", REGOUT2);
        end
        c = REGOUT1 | REGOUT2;
        checks++;
        if (c !== 8'hFF) begin
            errors++;
            $display("FAIL indep_or: got %h expected ff", c);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        HOLD = 1'b0;
        WRITEENABLE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 8'(i * 17 + 3);
            WRITEREG = 3'(i); WRITEDATA = v;
            tick();
        end
        checks++;
        if (WRITTEN !== 8'hFF) begin
            errors++;
            $display("FAIL mid_written_all: got %h expected ff", WRITTEN);
        end
        // reset lands while a write is pending
        WRITEREG = 3'd6; WRITEDATA = 8'h55;
        #2;
        RESETN = 1'b0;
        @(posedge CLK);
        #2;
        RESETN = 1'b1;
        WRITEENABLE = 1'b0;
        HOLD = 1'b1;
        READREG1 = 3'd6; READREG2 = 3'd6;
        tick();
        checks++;
        if (OUTVALID !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle_on_hold: got %b expected 0", OUTVALID);
        end
        HOLD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            READREG1 = 3'(i); READREG2 = 3'(7 - i);
            tick();
            checks++;
            if (REGOUT1 !== 8'h00 || REGOUT2 !== 8'h00) begin
                errors++;
                $display("FAIL mid_read_%0d: got %h/%h expected 00/00",
                         i, REGOUT1, REGOUT2);
            end
        end
        checks++;
        if (OUTVALID !== 1'b1 || WRITTEN !== 8'h00) begin
            errors++;
            $display("FAIL mid_final: got v%b w%h expected v1 w00",
                     OUTVALID, WRITTEN);
        end
    endtask

    initial begin
        RESETN = 1'b0;
        WRITEENABLE = 1'b0; WRITEREG = '0; WRITEDATA = '0;
        READREG1 = '0; READREG2 = '0; HOLD = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (REGOUT1 !== 8'h00 || OUTVALID !== 1'b0 || WRITTEN !== 8'h00) begin
            errors++;
            $display("FAIL por_state: got %h v%b w%h expected 00 v0 w00",
                     REGOUT1, OUTVALID, WRITTEN);
        end
        #2;
        RESETN = 1'b1;
        tick();
        test_reset();
        test_write_read();
        test_bypass();
        test_hold();
        test_independent();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
